fan_run_sequencer: RTL and testbench
====================================

Name: fan_run_sequencer

Overview:
- Central run controller for the desk-fan system.
- Takes single-cycle button pulses (speed, timer, swing), a 1 ms tick and ultrasonic distance samples.
- Sequences the motor speed level, with soft-start ramping and a proximity safety stop, and runs the off-timer countdown.
- Drives the motor PWM level select, the servo swing enable, the timer/status LEDs and the FND remaining-time value.

Parameters:
- TICK_PER_SEC, 1000: tick_msec pulses per second.
- RAMP_MS, 200: ms between soft-start level steps.
- PROX_CM, 9: object closer than this (cm) forces a stop.
- PROX_HOLD_SEC, 3: consecutive clear seconds before restarting after a proximity stop.

Ports:
- clk  in  1  system clock
- reset_p  in  1  synchronous active-high reset
- tick_msec  in  1  one-cycle pulse every 1 ms
- btn_speed  in  1  one-cycle debounced press pulse
- btn_timer  in  1  one-cycle debounced press pulse
- btn_swing  in  1  one-cycle debounced press pulse
- dist_valid  in  1  one-cycle strobe, distance is valid
- distance  in  12  measured distance, cm
- speed_sel  out  2  user-selected speed 0..3
- speed_lvl  out  2  applied motor level 0..3 (to PWM mux)
- swing_en  out  1  servo sweep enable
- timer_sel  out  2  0 = none, 1 = 1 min, 2 = 3 min, 3 = 5 min
- remain_sec  out  9  remaining timer seconds, 0..300
- prox_stop  out  1  high while in PROX_STOP

Behaviour:
- Reset: clk is the only clock; reset_p is synchronous active-high. All outputs are 0. state=OFF. Internal swing_req=0, ms_cnt=0, ramp_cnt=0, clear_cnt=0.
- States: OFF, RAMP, RUN, PROX_STOP (encoded 2 bits). All outputs are registered (1-cycle latency from input to output).
- Event priority within one cycle: reset > timer expiry > proximity trip > btn_speed > btn_timer / btn_swing. btn_timer and btn_swing are independent of each other and both apply in the same cycle.
- OFF:
  - speed_lvl=0, speed_sel=0, timer_sel=0, remain_sec=0.
  - btn_timer and btn_swing are ignored.
  - btn_speed: speed_sel=1, go to RAMP.
- RAMP:
  - ramp_cnt counts tick_msec. At RAMP_MS-1 plus a tick: ramp_cnt=0 and speed_lvl+=1.
  - When speed_lvl==speed_sel: go to RUN.
  - Entering RAMP from OFF or PROX_STOP starts at speed_lvl=0, so the first step is to 1 after RAMP_MS ms.
- RUN: speed_lvl=speed_sel.
- btn_speed in RAMP, RUN or PROX_STOP:
  - speed_sel+=1. Wrap 3->0 means full shutdown: go to OFF, clear timer_sel, remain_sec and swing_req.
  - In RAMP or RUN, a new speed_sel above speed_lvl goes to (or stays in) RAMP and continues from the current speed_lvl.
  - In PROX_STOP, btn_speed only updates speed_sel.
- Timer (active in any non-OFF state):
  - btn_timer cycles timer_sel 0->1->2->3->0 and loads remain_sec = 60 / 180 / 300 / 0. ms_cnt is cleared on each load.
  - While timer_sel!=0, ms_cnt counts ticks. At TICK_PER_SEC-1 plus a tick: ms_cnt=0 and remain_sec-=1.
  - Expiry: a decrement to 0 causes the same-cycle transition to OFF and clears speed_sel and timer_sel.
  - The timer keeps counting during PROX_STOP.
- Swing:
  - btn_swing toggles swing_req in RAMP or RUN; it is ignored in OFF and PROX_STOP.
  - swing_en = swing_req while in RAMP or RUN, otherwise 0. swing_req is retained across PROX_STOP.
- Proximity:
  - In RAMP or RUN, dist_valid with distance < PROX_CM: go to PROX_STOP, speed_lvl=0, prox_stop=1, clear_cnt=0.
  - In PROX_STOP, a sample < PROX_CM clears clear_cnt. Each elapsed second (own seconds divider, independent of the timer) with no close sample in that second increments clear_cnt.
  - clear_cnt==PROX_HOLD_SEC: go to RAMP if speed_sel!=0, otherwise go to OFF.
  - distance is compared unsigned over the full 12 bits. dist_valid without a close reading has no effect outside PROX_STOP.
- remain_sec never underflows. speed_lvl never exceeds speed_sel, except transiently in the FAN_BREEZE_EN mode below.

Optional Feature:
- Macro FAN_BREEZE_EN.
- Defined: in RUN with speed_sel==3, speed_lvl alternates 3 for 4 s, then 1 for 2 s, repeating.
  - The breeze phase counter resets on entering RUN.
  - Leaving speed_sel 3 restores steady speed_lvl=speed_sel.
- Undefined: speed_lvl=speed_sel in RUN, always steady. No breeze counter is synthesized.

Test Plan:
- All cases use TICK_PER_SEC=10, RAMP_MS=2, PROX_HOLD_SEC=3.
- Reset, then 3x btn_speed spaced 100 ticks apart -> speed_lvl steps 0->1 (2 ticks after first press), then ->2, ->3. speed_sel=3, state RUN. A 4th press -> OFF, all outputs 0.
- RUN at sel 2, btn_timer once -> timer_sel=1, remain_sec=60. After 600 ticks remain_sec=0 and state=OFF, speed_lvl=0, swing_en=0.
- RUN sel 2 with swing on, dist_valid with distance=5 -> prox_stop=1, speed_lvl=0, swing_en=0. Then valid samples of 20 every 5 ticks for 30 ticks -> RAMP; speed_lvl reaches 2 after 4 ticks; swing_en=1.
- PROX_STOP, a sample of 8 at tick 25 of 30 -> clear_cnt restarts, no restart until 30 clear ticks later.
- Same cycle: timer expiry + btn_speed + dist 3 -> OFF wins; speed_sel=0, prox_stop=0.
- With FAN_BREEZE_EN, RUN sel 3 -> speed_lvl 3 for 40 ticks, 1 for 20 ticks, repeating. btn_speed -> OFF.

Source files
------------

// File: rtl/fan_run_sequencer.sv
// Desk-fan run controller: soft-start speed sequencing, proximity safety stop and off-timer.
// Define FAN_BREEZE_EN to build the alternating breeze pattern at top speed.
module fan_run_sequencer #(
    parameter int TICK_PER_SEC  = 1000,
    parameter int RAMP_MS       = 200,
    parameter int PROX_CM       = 9,
    parameter int PROX_HOLD_SEC = 3
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        tick_msec,
    input  logic        btn_speed,
    input  logic        btn_timer,
    input  logic        btn_swing,
    input  logic        dist_valid,
    input  logic [11:0] distance,
    output logic [1:0]  speed_sel,
    output logic [1:0]  speed_lvl,
    output logic        swing_en,
    output logic [1:0]  timer_sel,
    output logic [8:0]  remain_sec,
    output logic        prox_stop
);
    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_PROX = 2'd3;

    localparam int MS_W   = (TICK_PER_SEC > 1) ? $clog2(TICK_PER_SEC) : 1;
    localparam int RAMP_W = (RAMP_MS > 1) ? $clog2(RAMP_MS) : 1;
    localparam int CLR_W  = $clog2(PROX_HOLD_SEC + 1);
    localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(TICK_PER_SEC - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_MS - 1);
    localparam logic [CLR_W-1:0]  CLR_HOLD  = CLR_W'(PROX_HOLD_SEC);

    logic [1:0]        state_q, state_d;
    logic [1:0]        speed_sel_q, speed_sel_d;
    logic [1:0]        speed_lvl_q, speed_lvl_d;
    logic              swing_req_q, swing_req_d;
    logic              swing_en_q, swing_en_d;
    logic [1:0]        timer_sel_q, timer_sel_d;
    logic [8:0]        remain_q, remain_d;
    logic              prox_stop_q, prox_stop_d;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [MS_W-1:0]   prox_ms_q, prox_ms_d;
    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [CLR_W-1:0]  clear_cnt_q, clear_cnt_d;
    logic              close_s, expire_s, shutdown_s, timer_btn_ok_s;

`ifdef FAN_BREEZE_EN
    localparam int BRZ_W = $clog2(6 * TICK_PER_SEC);
    localparam logic [BRZ_W-1:0] BRZ_LAST = BRZ_W'(6 * TICK_PER_SEC - 1);
    localparam logic [BRZ_W-1:0] BRZ_HIGH = BRZ_W'(4 * TICK_PER_SEC);
    logic [BRZ_W-1:0] brz_cnt_q, brz_cnt_d;
`endif

    function automatic logic [8:0] timer_load(input logic [1:0] sel);
        case (sel)
            2'd1:    timer_load = 9'd60;
            2'd2:    timer_load = 9'd180;
            2'd3:    timer_load = 9'd300;
            default: timer_load = 9'd0;
        endcase
    endfunction

    // Next-state logic for the run sequencer, timer and proximity hold-off.
    always_comb begin
        state_d        = state_q;
        speed_sel_d    = speed_sel_q;
        speed_lvl_d    = speed_lvl_q;
        swing_req_d    = swing_req_q;
        timer_sel_d    = timer_sel_q;
        remain_d       = remain_q;
        ms_cnt_d       = ms_cnt_q;
        prox_ms_d      = prox_ms_q;
        ramp_cnt_d     = ramp_cnt_q;
        clear_cnt_d    = clear_cnt_q;
        expire_s       = 1'b0;
        shutdown_s     = 1'b0;
        timer_btn_ok_s = 1'b0;
        close_s        = dist_valid && (distance < 12'(PROX_CM));
`ifdef FAN_BREEZE_EN
        brz_cnt_d      = (state_q == ST_RUN) ? brz_cnt_q : '0;
`endif

        if ((state_q != ST_OFF) && (timer_sel_q != 2'd0) && tick_msec) begin
            if (ms_cnt_q == MS_LAST) begin
                ms_cnt_d = '0;
                if (remain_q != 9'd0) begin
                    remain_d = remain_q - 9'd1;
                    expire_s = (remain_q == 9'd1);
                end else begin
                    remain_d = 9'd0;
                end
            end else begin
                ms_cnt_d = ms_cnt_q + MS_W'(1);
            end
        end else begin
            ms_cnt_d = ms_cnt_q;
        end

        case (state_q)
            ST_OFF: begin
                if (btn_speed) begin
                    speed_sel_d = 2'd1;
                    speed_lvl_d = 2'd0;
                    ramp_cnt_d  = '0;
                    state_d     = ST_RAMP;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_RAMP, ST_RUN: begin
                if (expire_s) begin
                    state_d = ST_OFF;
                end else if (close_s) begin
                    state_d     = ST_PROX;
                    speed_lvl_d = 2'd0;
                    clear_cnt_d = '0;
                    prox_ms_d   = '0;
                end else begin
                    timer_btn_ok_s = 1'b1;
                    if (state_q == ST_RAMP) begin
                        if (tick_msec) begin
                            if (ramp_cnt_q == RAMP_LAST) begin
                                ramp_cnt_d  = '0;
                                speed_lvl_d = speed_lvl_q + 2'd1;
                            end else begin
                                ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
                            end
                        end else begin
                            ramp_cnt_d = ramp_cnt_q;
                        end
                        state_d = (speed_lvl_d == speed_sel_q) ? ST_RUN : ST_RAMP;
                    end else begin
                        ramp_cnt_d = '0;
`ifdef FAN_BREEZE_EN
                        if (speed_sel_q == 2'd3) begin
                            if (tick_msec) begin
                                brz_cnt_d = (brz_cnt_q == BRZ_LAST) ? '0 : brz_cnt_q + BRZ_W'(1);
                            end else begin
                                brz_cnt_d = brz_cnt_q;
                            end
                            speed_lvl_d = (brz_cnt_d < BRZ_HIGH) ? 2'd3 : 2'd1;
                        end else begin
                            brz_cnt_d   = '0;
                            speed_lvl_d = speed_sel_q;
                        end
`else
                        speed_lvl_d = speed_sel_q;
`endif
                    end
                    // A raised selection keeps ramping from whatever level is applied now.
                    if (btn_speed) begin
                        if (speed_sel_q == 2'd3) begin
                            shutdown_s = 1'b1;
                        end else begin
                            speed_sel_d = speed_sel_q + 2'd1;
                            state_d     = ST_RAMP;
                        end
                    end else begin
                        speed_sel_d = speed_sel_q;
                    end
                    swing_req_d = btn_swing ? ~swing_req_q : swing_req_q;
                end
            end
            ST_PROX: begin
                timer_btn_ok_s = 1'b1;
                if (close_s) begin
                    clear_cnt_d = '0;
                    prox_ms_d   = '0;
                end else if (tick_msec) begin
                    if (prox_ms_q == MS_LAST) begin
                        prox_ms_d   = '0;
                        clear_cnt_d = clear_cnt_q + CLR_W'(1);
                    end else begin
                        prox_ms_d = prox_ms_q + MS_W'(1);
                    end
                end else begin
                    prox_ms_d = prox_ms_q;
                end
                if (btn_speed) begin
                    if (speed_sel_q == 2'd3) begin
                        shutdown_s = 1'b1;
                    end else begin
                        speed_sel_d = speed_sel_q + 2'd1;
                    end
                end else begin
                    speed_sel_d = speed_sel_q;
                end
                if (clear_cnt_d == CLR_HOLD) begin
                    clear_cnt_d = '0;
                    prox_ms_d   = '0;
                    ramp_cnt_d  = '0;
                    speed_lvl_d = 2'd0;
                    state_d     = (speed_sel_d != 2'd0) ? ST_RAMP : ST_OFF;
                end else begin
                    state_d = ST_PROX;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        // Expiry keeps the swing preference; a user shutdown forgets it.
        if (expire_s || shutdown_s) begin
            state_d     = ST_OFF;
            speed_sel_d = 2'd0;
            speed_lvl_d = 2'd0;
            timer_sel_d = 2'd0;
            remain_d    = 9'd0;
            ms_cnt_d    = '0;
            swing_req_d = expire_s ? swing_req_q : 1'b0;
        end else if (timer_btn_ok_s && btn_timer) begin
            timer_sel_d = timer_sel_q + 2'd1;
            remain_d    = timer_load(timer_sel_q + 2'd1);
            ms_cnt_d    = '0;
        end else begin
            timer_sel_d = timer_sel_q;
        end

        swing_en_d  = swing_req_d && ((state_d == ST_RAMP) || (state_d == ST_RUN));
        prox_stop_d = (state_d == ST_PROX);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q     <= ST_OFF;
            speed_sel_q <= 2'd0;
            speed_lvl_q <= 2'd0;
            swing_req_q <= 1'b0;
            swing_en_q  <= 1'b0;
            timer_sel_q <= 2'd0;
            remain_q    <= 9'd0;
            prox_stop_q <= 1'b0;
            ms_cnt_q    <= '0;
            prox_ms_q   <= '0;
            ramp_cnt_q  <= '0;
            clear_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            speed_sel_q <= speed_sel_d;
            speed_lvl_q <= speed_lvl_d;
            swing_req_q <= swing_req_d;
            swing_en_q  <= swing_en_d;
            timer_sel_q <= timer_sel_d;
            remain_q    <= remain_d;
            prox_stop_q <= prox_stop_d;
            ms_cnt_q    <= ms_cnt_d;
            prox_ms_q   <= prox_ms_d;
            ramp_cnt_q  <= ramp_cnt_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

`ifdef FAN_BREEZE_EN
    // Breeze phase counter.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            brz_cnt_q <= '0;
        end else begin
            brz_cnt_q <= brz_cnt_d;
        end
    end
`endif

    assign speed_sel  = speed_sel_q;
    assign speed_lvl  = speed_lvl_q;
    assign swing_en   = swing_en_q;
    assign timer_sel  = timer_sel_q;
    assign remain_sec = remain_q;
    assign prox_stop  = prox_stop_q;
endmodule

// File: tb/tb_fan_run_sequencer.sv
// Bench for fan_run_sequencer: behavioural model compared every cycle plus literal spot checks.
module tb_fan_run_sequencer;
    localparam int P_TPS  = 10;
    localparam int P_RAMP = 2;
    localparam int P_CM   = 9;
    localparam int P_HOLD = 3;
    localparam int M_OFF = 0, M_RAMP = 1, M_RUN = 2, M_PROX = 3;

    logic        clk = 1'b0;
    logic        reset_p = 1'b0;
    logic        tick_msec = 1'b0;
    logic        btn_speed = 1'b0;
    logic        btn_timer = 1'b0;
    logic        btn_swing = 1'b0;
    logic        dist_valid = 1'b0;
    logic [11:0] distance = 12'd0;
    logic [1:0]  speed_sel, speed_lvl, timer_sel;
    logic        swing_en, prox_stop;
    logic [8:0]  remain_sec;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int m_mode = M_OFF, m_sel = 0, m_lvl = 0, m_timer = 0, m_remain = 0, m_swing = 0;
    int m_msdiv = 0, m_rampdiv = 0, m_clear = 0, m_proxdiv = 0, m_brz = 0;
    int minutes [4] = '{0, 1, 3, 5};

    fan_run_sequencer #(
        .TICK_PER_SEC (P_TPS),
        .RAMP_MS      (P_RAMP),
        .PROX_CM      (P_CM),
        .PROX_HOLD_SEC(P_HOLD)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .tick_msec (tick_msec),
        .btn_speed (btn_speed),
        .btn_timer (btn_timer),
        .btn_swing (btn_swing),
        .dist_valid(dist_valid),
        .distance  (distance),
        .speed_sel (speed_sel),
        .speed_lvl (speed_lvl),
        .swing_en  (swing_en),
        .timer_sel (timer_sel),
        .remain_sec(remain_sec),
        .prox_stop (prox_stop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic go_off(input bit keep_swing);
        m_mode = M_OFF; m_sel = 0; m_lvl = 0; m_timer = 0; m_remain = 0; m_msdiv = 0;
        if (!keep_swing) m_swing = 0;
    endtask

    // Model: apply this cycle's events in priority order to the user-visible fan state.
    task automatic model_step();
        int m0;
        bit close;
        if (m_mode != M_RUN) m_brz = 0;
        if (reset_p) begin
            go_off(1'b0);
            m_rampdiv = 0; m_clear = 0; m_proxdiv = 0; m_brz = 0;
            return;
        end
        m0 = m_mode;
        close = dist_valid && (int'(distance) < P_CM);
        if (m0 != M_OFF && m_timer != 0 && tick_msec) begin
            m_msdiv++;
            if (m_msdiv == P_TPS) begin
                m_msdiv = 0;
                if (m_remain > 0) m_remain--;
                if (m_remain == 0) begin go_off(1'b1); return; end
            end
        end
        if ((m0 == M_RAMP || m0 == M_RUN) && close) begin
            m_mode = M_PROX; m_lvl = 0; m_clear = 0; m_proxdiv = 0;
            return;
        end
        if (m0 == M_OFF) begin
            if (btn_speed) begin m_sel = 1; m_lvl = 0; m_rampdiv = 0; m_mode = M_RAMP; end
            return;
        end
        if (m0 == M_PROX) begin
            if (close) begin
                m_clear = 0; m_proxdiv = 0;
            end else if (tick_msec) begin
                m_proxdiv++;
                if (m_proxdiv == P_TPS) begin m_proxdiv = 0; m_clear++; end
            end
        end else if (m0 == M_RAMP) begin
            if (tick_msec) begin
                m_rampdiv++;
                if (m_rampdiv == P_RAMP) begin m_rampdiv = 0; m_lvl++; end
            end
            if (m_lvl == m_sel) m_mode = M_RUN;
        end else begin
`ifdef FAN_BREEZE_EN
            if (m_sel == 3) begin
                if (tick_msec) m_brz = (m_brz + 1) % (6 * P_TPS);
                m_lvl = (m_brz < 4 * P_TPS) ? 3 : 1;
            end else begin
                m_lvl = m_sel;
            end
`else
            m_lvl = m_sel;
`endif
        end
        if (btn_speed) begin
            if (m_sel == 3) begin go_off(1'b0); return; end
            m_sel++;
            if (m_mode == M_RUN) begin m_mode = M_RAMP; m_rampdiv = 0; end
        end
        if (m0 == M_PROX && m_clear == P_HOLD) begin
            m_clear = 0; m_proxdiv = 0; m_lvl = 0; m_rampdiv = 0;
            m_mode = (m_sel != 0) ? M_RAMP : M_OFF;
        end
        if (btn_timer) begin
            m_timer = (m_timer + 1) % 4;
            m_remain = minutes[m_timer] * 60;
            m_msdiv = 0;
        end
        if (btn_swing && (m0 == M_RAMP || m0 == M_RUN)) m_swing = 1 - m_swing;
    endtask

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("speed_sel", int'(speed_sel), m_sel);
            check("speed_lvl", int'(speed_lvl), m_lvl);
            check("timer_sel", int'(timer_sel), m_timer);
            check("remain_sec", int'(remain_sec), m_remain);
            check("swing_en", int'(swing_en), (m_swing != 0 && (m_mode == M_RAMP || m_mode == M_RUN)) ? 1 : 0);
            check("prox_stop", int'(prox_stop), (m_mode == M_PROX) ? 1 : 0);
        end
    end

    task automatic cyc(input bit tk, input bit bs, input bit bt, input bit bw, input bit dv, input int d);
        tick_msec = tk; btn_speed = bs; btn_timer = bt; btn_swing = bw;
        dist_valid = dv; distance = 12'(d);
        @(posedge clk);
        model_step();
        #1;
        tick_msec = 1'b0; btn_speed = 1'b0; btn_timer = 1'b0; btn_swing = 1'b0;
        dist_valid = 1'b0; distance = 12'd0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
    endtask

    task automatic press_speed(); cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0); endtask
    task automatic press_timer(); cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0); endtask
    task automatic press_swing(); cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0); endtask
    task automatic sample(input int d); cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d); endtask

    initial begin
        reset_p = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        reset_p = 1'b0;
        chk_en = 1'b1;
        check("rst_sel", int'(speed_sel), 0);
        check("rst_lvl", int'(speed_lvl), 0);
        check("rst_remain", int'(remain_sec), 0);
        check("rst_prox", int'(prox_stop), 0);

        // Soft-start through all three levels, then wrap to off.
        press_speed();
        check("p1_sel", int'(speed_sel), 1);
        ticks(1);
        check("p1_lvl_t1", int'(speed_lvl), 0);
        ticks(1);
        check("p1_lvl_t2", int'(speed_lvl), 1);
        ticks(98);
        press_speed();
        ticks(100);
        check("p2_lvl", int'(speed_lvl), 2);
        press_speed();
        ticks(100);
        check("p3_lvl", int'(speed_lvl), 3);
        check("p3_sel", int'(speed_sel), 3);
        press_speed();
        check("wrap_sel", int'(speed_sel), 0);
        check("wrap_lvl", int'(speed_lvl), 0);
        press_timer();
        check("off_timer_ignored", int'(timer_sel), 0);

        // Timer cycling and a full 60 s countdown to expiry.
        press_speed(); press_speed();
        ticks(4);
        check("s2_lvl", int'(speed_lvl), 2);
        press_timer(); check("t1_remain", int'(remain_sec), 60);
        press_timer(); check("t2_remain", int'(remain_sec), 180);
        press_timer(); check("t3_remain", int'(remain_sec), 300);
        press_timer(); check("t0_remain", int'(remain_sec), 0);
        press_timer(); check("t1b_sel", int'(timer_sel), 1);
        ticks(599);
        check("cd_remain1", int'(remain_sec), 1);
        ticks(1);
        check("cd_remain0", int'(remain_sec), 0);
        check("cd_lvl", int'(speed_lvl), 0);
        check("cd_sel", int'(speed_sel), 0);

        // Proximity stop and timed recovery.
        press_speed(); press_speed();
        ticks(4);
        press_swing();
        check("swing_on", int'(swing_en), 1);
        sample(9);
        check("dist9_no_trip", int'(prox_stop), 0);
        sample(4095);
        sample(5);
        check("trip_prox", int'(prox_stop), 1);
        check("trip_lvl", int'(speed_lvl), 0);
        check("trip_swing", int'(swing_en), 0);
        for (int i = 1; i <= 29; i++) begin
            ticks(1);
            if (i % 5 == 0) sample(20);
        end
        check("hold_prox", int'(prox_stop), 1);
        ticks(1);
        check("release_prox", int'(prox_stop), 0);
        ticks(4);
        check("reramp_lvl", int'(speed_lvl), 2);
        check("reramp_swing", int'(swing_en), 1);

        // Close sample mid-hold restarts the clear count.
        sample(8);
        check("trip8_prox", int'(prox_stop), 1);
        press_speed();
        check("prox_btn_sel", int'(speed_sel), 3);
        check("prox_btn_lvl", int'(speed_lvl), 0);
        ticks(25);
        sample(8);
        ticks(29);
        check("rehold_prox", int'(prox_stop), 1);
        ticks(1);
        check("rerelease_prox", int'(prox_stop), 0);
        ticks(6);
        check("reramp3_lvl", int'(speed_lvl), 3);

        // Expiry, speed press and close sample in the same cycle.
        press_speed();
        press_speed();
        ticks(2);
        press_timer();
        ticks(599);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3);
        check("combo_sel", int'(speed_sel), 0);
        check("combo_prox", int'(prox_stop), 0);
        check("combo_lvl", int'(speed_lvl), 0);
        check("combo_timer", int'(timer_sel), 0);

`ifdef FAN_BREEZE_EN
        press_speed(); press_speed(); press_speed();
        ticks(6);
        check("brz_hi", int'(speed_lvl), 3);
        ticks(40);
        check("brz_lo", int'(speed_lvl), 1);
        ticks(20);
        check("brz_hi2", int'(speed_lvl), 3);
        press_speed();
        check("brz_off", int'(speed_lvl), 0);
`endif
        ticks(5);
        chk_en = 1'b0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
